// File: rtl/op_imm_sequencer_pkg.sv
// Shared CPU constants for the OP-IMM microsequencer and its decoder minterms.
package op_imm_sequencer_pkg;

    localparam int IR_W  = 32;
    localparam int CNT_W = 32;

    // Microstate encoding seen by every decoder minterm; IDLE selects no minterm.
    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        IDLE = 3'd3
    } mstate_e;

    // A returned next state is malformed if it is out of range (4..7) or does
    // not move strictly forward through the microsequence.
    function automatic logic nstate_fault(logic [2:0] ns, mstate_e cur);
        return ns[2] || (ns <= cur);
    endfunction

endpackage

// File: rtl/op_imm_sequencer_if.sv
// Fetch / decoder / datapath signals of the OP-IMM microsequencer.
interface op_imm_sequencer_if;
    import op_imm_sequencer_pkg::*;

    logic             ir_valid_i;
    logic [IR_W-1:0]  ir_i;
    logic             ir_ready_o;
    logic [2:0]       cstate_o;
    logic [IR_W-1:0]  ir_o;
    logic [2:0]       nstate_i;
    logic             defined_i;
    logic             stall_i;
    logic             flush_i;
    logic             done_o;
    logic             trap_o;
    logic [CNT_W-1:0] retire_count_o;

    // Sequencer side.
    modport slave (
        input  ir_valid_i, ir_i, nstate_i, defined_i, stall_i, flush_i,
        output ir_ready_o, cstate_o, ir_o, done_o, trap_o, retire_count_o
    );

    // Surrounding CPU side (fetch, decoders, datapath).
    modport master (
        output ir_valid_i, ir_i, nstate_i, defined_i, stall_i, flush_i,
        input  ir_ready_o, cstate_o, ir_o, done_o, trap_o, retire_count_o
    );

endinterface

// File: rtl/op_imm_sequencer.sv
// OP-IMM microsequencer: holds the accepted instruction, walks S0->S1->S2
// under decoder control, retires or traps, and counts retired instructions.
module op_imm_sequencer
    import op_imm_sequencer_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    op_imm_sequencer_if.slave  bus
);

    mstate_e          cstate_q, cstate_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic             done_q, done_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready;

    // Acceptance is only possible from IDLE and is blocked by flush or reset.
    assign ready = (cstate_q == IDLE) & ~bus.flush_i & ~reset_i;

    assign bus.ir_ready_o     = ready;
    assign bus.cstate_o       = cstate_q;
    assign bus.ir_o           = ir_q;
    assign bus.done_o         = done_q;
    assign bus.trap_o         = trap_q;
    assign bus.retire_count_o = cnt_q;

    // Next-state logic: flush beats everything, then acceptance, stall, sequencing.
    always_comb begin
        cstate_d = cstate_q;
        ir_d     = ir_q;
        done_d   = 1'b0;
        trap_d   = 1'b0;
        cnt_d    = cnt_q;

        if (bus.flush_i) begin
            cstate_d = IDLE;
        end else if (cstate_q == IDLE) begin
            if (bus.ir_valid_i && ready) begin
                ir_d     = bus.ir_i;
                cstate_d = S0;
            end
        end else if (!bus.stall_i) begin
            if ((cstate_q == S0) && !bus.defined_i) begin
                cstate_d = IDLE;
                trap_d   = 1'b1;
            end else if (nstate_fault(bus.nstate_i, cstate_q)) begin
                cstate_d = IDLE;
                trap_d   = 1'b1;
            end else if (bus.nstate_i == IDLE) begin
                // Retire: done is visible in the IDLE cycle together with the new count.
                cstate_d = IDLE;
                done_d   = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
            end else begin
                cstate_d = mstate_e'(bus.nstate_i);
            end
        end
    end

    // State registers; reset clears everything immediately, abandoning any instruction.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cstate_q <= IDLE;
            ir_q     <= '0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cstate_q <= cstate_d;
            ir_q     <= ir_d;
            done_q   <= done_d;
            trap_q   <= trap_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_op_imm_sequencer.sv
// Self-checking bench for op_imm_sequencer with a transaction-level reference model.
module tb_op_imm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_conf;
    logic [2:0] ns_rand;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_state;
    logic [31:0] m_ir;
    logic [31:0] m_cnt;
    logic        m_done;
    logic        m_trap;

    op_imm_sequencer_if bus();

    op_imm_sequencer dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Decoder stand-in: conforming decoder steps to the next microstate,
    // otherwise it returns an arbitrary value.
    always_comb bus.nstate_i = dec_conf ? (bus.cstate_o + 3'd1) : ns_rand;

    function automatic logic m_ready();
        return (m_state == 3) && !bus.flush_i && !rst;
    endfunction

    task automatic model_reset();
        m_state = 3;
        m_ir    = '0;
        m_cnt   = '0;
        m_done  = 1'b0;
        m_trap  = 1'b0;
    endtask

    // One clock edge; the model applies the instruction-lifecycle rules.
    task automatic tick();
        int ns;
        ns = dec_conf ? m_state + 1 : int'(ns_rand);
        @(posedge clk);
        m_done = 1'b0;
        m_trap = 1'b0;
        if (bus.flush_i) begin
            m_state = 3;
        end else if (m_state == 3) begin
            if (bus.ir_valid_i) begin
                m_ir    = bus.ir_i;
                m_state = 0;
            end
        end else if (!bus.stall_i) begin
            if ((m_state == 0 && !bus.defined_i) || ns > 3 || ns <= m_state) begin
                m_state = 3;
                m_trap  = 1'b1;
            end else if (ns == 3) begin
                m_state = 3;
                m_done  = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end else begin
                m_state = ns;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ir_valid_i = 1'b0; bus.ir_i = '0; bus.defined_i = 1'b0;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0; dec_conf = 1'b1; ns_rand = '0;
        model_reset();
        #3;
        n_cmp++; if (bus.cstate_o !== 3'd3) begin n_err++; $display("FAIL reset_cstate got %0d want 3", bus.cstate_o); end
        n_cmp++; if (bus.ir_o !== 32'd0) begin n_err++; $display("FAIL reset_ir got %h want 0", bus.ir_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        n_cmp++; if (bus.trap_o !== 1'b0) begin n_err++; $display("FAIL reset_trap got %b want 0", bus.trap_o); end
        n_cmp++; if (bus.retire_count_o !== 32'd0) begin n_err++; $display("FAIL reset_count got %h want 0", bus.retire_count_o); end
        n_cmp++; if (bus.ir_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.ir_ready_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.ir_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", bus.ir_ready_o); end
    endtask

    task automatic test_addi();
        bus.ir_i = 32'h00510093; bus.ir_valid_i = 1'b1; bus.defined_i = 1'b1; dec_conf = 1'b1;
        #1;
        n_cmp++; if (bus.ir_ready_o !== m_ready()) begin n_err++; $display("FAIL addi_ready got %b want %b", bus.ir_ready_o, m_ready()); end
        tick();
        bus.ir_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.cstate_o !== 3'(i)) begin n_err++; $display("FAIL addi_cstate[%0d] got %0d want %0d", i, bus.cstate_o, i); end
            n_cmp++; if (bus.done_o !== m_done) begin n_err++; $display("FAIL addi_done[%0d] got %b want %b", i, bus.done_o, m_done); end
            if (i < 3) tick();
        end
        n_cmp++; if (bus.retire_count_o !== 32'd1) begin n_err++; $display("FAIL addi_count got %h want 1", bus.retire_count_o); end
        n_cmp++; if (bus.ir_o !== 32'h00510093) begin n_err++; $display("FAIL addi_ir got %h want 00510093", bus.ir_o); end
        tick();
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL addi_done_pulse got %b want 0", bus.done_o); end
    endtask

    task automatic test_illegal();
        bus.ir_i = 32'h0000000B; bus.ir_valid_i = 1'b1; bus.defined_i = 1'b0;
        #1;
        tick();
        bus.ir_valid_i = 1'b0;
        n_cmp++; if (bus.cstate_o !== 3'd0) begin n_err++; $display("FAIL ill_s0 got %0d want 0", bus.cstate_o); end
        tick();
        n_cmp++; if (bus.trap_o !== 1'b1) begin n_err++; $display("FAIL ill_trap got %b want 1", bus.trap_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL ill_done got %b want 0", bus.done_o); end
        n_cmp++; if (bus.cstate_o !== 3'd3) begin n_err++; $display("FAIL ill_cstate got %0d want 3", bus.cstate_o); end
        n_cmp++; if (bus.ir_o !== 32'h0000000B) begin n_err++; $display("FAIL ill_ir got %h want 0000000b", bus.ir_o); end
        n_cmp++; if (bus.retire_count_o !== m_cnt) begin n_err++; $display("FAIL ill_count got %h want %h", bus.retire_count_o, m_cnt); end
        tick();
        n_cmp++; if (bus.trap_o !== 1'b0) begin n_err++; $display("FAIL ill_trap_pulse got %b want 0", bus.trap_o); end
        bus.defined_i = 1'b1;
    endtask

    task automatic test_stall();
        int s1_cycles;
        int done_at;
        bus.ir_i = 32'h00510093; bus.ir_valid_i = 1'b1;
        #1;
        tick();
        bus.ir_valid_i = 1'b0;
        tick();
        s1_cycles = 1;
        done_at = -1;
        bus.stall_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) bus.stall_i = 1'b0;
            tick();
            if (bus.cstate_o == 3'd1) s1_cycles++;
            if (bus.done_o === 1'b1 && done_at < 0) done_at = i;
            n_cmp++; if (bus.cstate_o !== 3'(m_state)) begin n_err++; $display("FAIL stall_cstate[%0d] got %0d want %0d", i, bus.cstate_o, m_state); end
            n_cmp++; if (bus.done_o !== m_done || bus.trap_o !== m_trap) begin n_err++; $display("FAIL stall_pulses[%0d] got %b%b want %b%b", i, bus.done_o, bus.trap_o, m_done, m_trap); end
        end
        n_cmp++; if (s1_cycles !== 5) begin n_err++; $display("FAIL stall_s1_len got %0d want 5", s1_cycles); end
        n_cmp++; if (done_at !== 5) begin n_err++; $display("FAIL stall_done_cycle got %0d want 5", done_at); end
    endtask

    task automatic test_flush();
        logic [31:0] held;
        bus.ir_i = 32'hCAFE0093; bus.ir_valid_i = 1'b1;
        #1;
        tick();
        bus.ir_valid_i = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.cstate_o !== 3'd2) begin n_err++; $display("FAIL flush_pre got %0d want 2", bus.cstate_o); end
        bus.flush_i = 1'b1; bus.ir_valid_i = 1'b1;
        #1;
        n_cmp++; if (bus.ir_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", bus.ir_ready_o); end
        tick();
        n_cmp++; if (bus.cstate_o !== 3'd3) begin n_err++; $display("FAIL flush_cstate got %0d want 3", bus.cstate_o); end
        n_cmp++; if (bus.done_o !== 1'b0 || bus.trap_o !== 1'b0) begin n_err++; $display("FAIL flush_pulses got %b%b want 00", bus.done_o, bus.trap_o); end
        n_cmp++; if (bus.retire_count_o !== m_cnt) begin n_err++; $display("FAIL flush_count got %h want %h", bus.retire_count_o, m_cnt); end
        // Flush while idle only blocks acceptance.
        held = bus.ir_o;
        bus.ir_i = 32'h12345678;
        #1;
        n_cmp++; if (bus.ir_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready got %b want 0", bus.ir_ready_o); end
        tick();
        n_cmp++; if (bus.cstate_o !== 3'd3 || bus.ir_o !== held) begin n_err++; $display("FAIL flush_idle got %0d/%h want 3/%h", bus.cstate_o, bus.ir_o, held); end
        bus.flush_i = 1'b0; bus.ir_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [31:0] want_cnt [3];
        want_cnt[0] = 32'h0; want_cnt[1] = 32'h1; want_cnt[2] = 32'h2;
        ndone = 0;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        n_cmp++; if (bus.retire_count_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_preset got %h want ffffffff", bus.retire_count_o); end
        bus.ir_valid_i = 1'b1; bus.defined_i = 1'b1; dec_conf = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.ir_i = $urandom;
            #1;
            n_cmp++; if (bus.ir_ready_o !== m_ready()) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", i, bus.ir_ready_o, m_ready()); end
            tick();
            n_cmp++; if (bus.cstate_o !== 3'(m_state) || bus.ir_o !== m_ir) begin n_err++; $display("FAIL b2b_state[%0d] got %0d/%h want %0d/%h", i, bus.cstate_o, bus.ir_o, m_state, m_ir); end
            n_cmp++; if (bus.done_o !== m_done) begin n_err++; $display("FAIL b2b_done[%0d] got %b want %b", i, bus.done_o, m_done); end
            if (bus.done_o === 1'b1) begin
                if (ndone < 3) begin
                    n_cmp++; if (bus.retire_count_o !== want_cnt[ndone]) begin n_err++; $display("FAIL b2b_count[%0d] got %h want %h", ndone, bus.retire_count_o, want_cnt[ndone]); end
                end
                ndone++;
            end
        end
        n_cmp++; if (ndone !== 3) begin n_err++; $display("FAIL b2b_ndone got %0d want 3", ndone); end
        bus.ir_valid_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.ir_valid_i = 1'($urandom_range(0, 1));
            bus.ir_i       = $urandom;
            bus.flush_i    = ($urandom_range(0, 7) == 0);
            bus.stall_i    = ($urandom_range(0, 3) == 0);
            bus.defined_i  = ($urandom_range(0, 7) != 0);
            dec_conf       = ($urandom_range(0, 3) != 0);
            ns_rand        = 3'($urandom_range(0, 7));
            #1;
            n_cmp++; if (bus.ir_ready_o !== m_ready()) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, bus.ir_ready_o, m_ready()); end
            tick();
            n_cmp++; if (bus.cstate_o !== 3'(m_state)) begin n_err++; $display("FAIL rnd_cstate[%0d] got %0d want %0d", i, bus.cstate_o, m_state); end
            n_cmp++; if (bus.ir_o !== m_ir) begin n_err++; $display("FAIL rnd_ir[%0d] got %h want %h", i, bus.ir_o, m_ir); end
            n_cmp++; if (bus.done_o !== m_done) begin n_err++; $display("FAIL rnd_done[%0d] got %b want %b", i, bus.done_o, m_done); end
            n_cmp++; if (bus.trap_o !== m_trap) begin n_err++; $display("FAIL rnd_trap[%0d] got %b want %b", i, bus.trap_o, m_trap); end
            n_cmp++; if (bus.retire_count_o !== m_cnt) begin n_err++; $display("FAIL rnd_count[%0d] got %h want %h", i, bus.retire_count_o, m_cnt); end
            n_cmp++; if ((bus.done_o & bus.trap_o) !== 1'b0) begin n_err++; $display("FAIL rnd_excl[%0d] got done&trap=1 want 0", i); end
        end
        bus.flush_i = 1'b0; bus.stall_i = 1'b0; bus.defined_i = 1'b1;
        bus.ir_valid_i = 1'b0; dec_conf = 1'b1;
        // Drain to IDLE.
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_async_reset();
        bus.ir_i = 32'h00510093; bus.ir_valid_i = 1'b1; bus.defined_i = 1'b1; dec_conf = 1'b1;
        #1;
        tick();
        bus.ir_valid_i = 1'b0;
        tick();
        n_cmp++; if (bus.cstate_o !== 3'd1) begin n_err++; $display("FAIL ares_pre got %0d want 1", bus.cstate_o); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (bus.cstate_o !== 3'd3 || bus.ir_o !== 32'd0) begin n_err++; $display("FAIL ares_clear got %0d/%h want 3/0", bus.cstate_o, bus.ir_o); end
        n_cmp++; if (bus.retire_count_o !== 32'd0 || bus.ir_ready_o !== 1'b0) begin n_err++; $display("FAIL ares_cnt_rdy got %h/%b want 0/0", bus.retire_count_o, bus.ir_ready_o); end
        n_cmp++; if (bus.done_o !== 1'b0 || bus.trap_o !== 1'b0) begin n_err++; $display("FAIL ares_pulses got %b%b want 00", bus.done_o, bus.trap_o); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done_o !== 1'b0 || bus.trap_o !== 1'b0 || bus.cstate_o !== 3'd3) begin n_err++; $display("FAIL ares_hold got %b%b/%0d want 00/3", bus.done_o, bus.trap_o, bus.cstate_o); end
        bus.ir_i = 32'h00A00113; bus.ir_valid_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.ir_ready_o !== 1'b1) begin n_err++; $display("FAIL ares_ready got %b want 1", bus.ir_ready_o); end
        tick();
        n_cmp++; if (bus.cstate_o !== 3'd0 || bus.ir_o !== 32'h00A00113) begin n_err++; $display("FAIL ares_accept got %0d/%h want 0/00a00113", bus.cstate_o, bus.ir_o); end
        bus.ir_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_illegal();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
